fetch: RTL and testbench
========================

Name: fetch

Overview:
- Instruction fetch stage, the producer end of the {pc, ir} instruction stream that decode consumes.
- Holds the program counter and issues single-beat reads on an AXI4-Lite-style instruction read channel.
- Presents each returned instruction with its PC on an AXI-stream master register slice.
- Accepts PC redirects from execute and discards stale in-flight responses.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset; synchronous, active-high.
- redirect  in  1  one-cycle pulse from execute: taken branch or jump.
- target  in  32  new PC, sampled when redirect=1.
- ar_valid  out  1  instruction read address valid.
- ar_ready  in  1  instruction read address ready.
- ar_addr  out  32  instruction read address.
- r_valid  in  1  read data valid.
- r_ready  out  1  read data ready.
- r_data  in  32  instruction word.
- r_resp  in  2  read response; 2'b00 = OKAY, anything else = error.
- tvalid  out  1  instruction stream valid.
- tready  in  1  instruction stream ready, from decode.
- tdata  out  64  {pc[63:32], ir[31:0]}.
- misaligned  out  1  sticky: redirect target had [1:0] != 0.
- bus_error  out  1  sticky: a non-discarded response had r_resp != OKAY.

Behaviour:
- Reset state (areset=1 at the edge):
  - pc=RESET_ADDR, request FSM=IDLE, kill=0.
  - ar_valid=0, r_ready=0, tvalid=0, tdata=0, misaligned=0, bus_error=0.
- Request FSM states: IDLE, REQ, WAIT, HALT.
- IDLE: moves to REQ on the first cycle after reset deasserts.
- REQ:
  - ar_valid=1, ar_addr=pc.
  - On ar_valid & ar_ready, go to WAIT.
  - ar_addr stays stable while ar_valid=1 and ar_ready=0, even across a redirect (AXI rule).
- WAIT:
  - r_ready = ~tvalid | tready, i.e. the output register is empty or draining this cycle.
  - On r_valid & r_ready with kill=0 and r_resp=OKAY: tdata<={pc, r_data}, tvalid<=1, pc<=pc+4, go to REQ.
  - On r_valid & r_ready with kill=1: drop the data (no tvalid, no pc increment), clear kill, go to REQ.
  - On r_valid & r_ready with kill=0 and r_resp!=OKAY: bus_error<=1, go to HALT, nothing is emitted.
- HALT:
  - ar_valid=0, r_ready=0.
  - Left only by reset.
  - tvalid already asserted still drains normally.
- Output register:
  - tvalid clears on tvalid & tready unless reloaded in the same cycle.
  - tdata is stable while tvalid=1 and tready=0.
- Throughput: one instruction per 2 cycles with zero-latency memory (REQ, then WAIT).
  - Latency from ar handshake to tvalid is 1 cycle after r_valid.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 = 32'h0.
- Redirect, aligned target (target[1:0]==0), applied at the edge:
  - pc<=target.
  - tvalid<=0 (flush), overriding any capture or hold in the same cycle.
  - REQ with ar_ready=0: keep ar_valid with the old address; set kill. The response of that request is dropped.
  - REQ with ar_ready=1: the handshake completes with the old address; set kill.
  - WAIT without a same-cycle r handshake: set kill.
  - WAIT with a same-cycle r handshake: drop the response, kill stays 0, go to REQ with the new pc.
  - IDLE: pc<=target only.
  - HALT: ignored.
- Redirect, misaligned target (target[1:0]!=0):
  - misaligned<=1, tvalid<=0.
  - FSM goes to HALT once any outstanding request has completed: kill is set, and HALT is entered after that response is consumed.
- Redirect and r_resp error in the same cycle: the response is discarded and bus_error is not set.
- Reset mid-transaction: state returns to the reset values immediately. An r_valid arriving after reset is ignored because r_ready=0 in IDLE.
- At most one read is outstanding at any time.

Test Plan:
- Reset with RESET_ADDR=32'h100; zero-wait memory returning 32'h13+pc; tready=1. Required: ar_addr 0x100, 0x104, 0x108; tdata {0x100,0x113}, {0x104,0x117}; tvalid pulses every 2 cycles.
- Hold tready=0 for 5 cycles after the first output. Required: tdata stays {0x100,0x113}; r_ready=0 while a response is pending; exactly one ar handshake during the stall; the stream resumes in order with no loss or duplication.
- Redirect to 32'h200 during WAIT, with r_valid arriving 2 cycles later. Required: that response is dropped, tvalid=0; the next ar_addr is 0x200; the next tdata is {0x200, mem[0x200]}.
- Redirect to 32'h300 while in REQ with ar_ready=0 for 3 cycles. Required: ar_addr holds the old PC until the handshake; its response is dropped; then ar_addr=0x300.
- Redirect target 32'h402. Required: misaligned=1, tvalid=0, ar_valid stays 0 after any pending response completes; reset clears the condition.
- Response with r_resp=2'b10 at pc 0x108. Required: bus_error=1, no tvalid for 0x108, no further ar_valid; the PC wrap check from 32'hFFFF_FFFC produces the next ar_addr 32'h0.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues single-beat instruction reads and
// presents {pc, ir} on a registered stream output; redirects kill stale responses.
module fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        redirect,
    input  logic [31:0] target,
    output logic        ar_valid,
    input  logic        ar_ready,
    output logic [31:0] ar_addr,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    output logic        tvalid,
    input  logic        tready,
    output logic [63:0] tdata,
    output logic        misaligned,
    output logic        bus_error
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a producer holds valid and its payload stable until that transfer completes.
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] addr_q, addr_next;
    logic        kill, kill_next;
    logic        halt_pend, halt_pend_next;
    logic        tvalid_next;
    logic [63:0] tdata_next;
    logic        mis_next, berr_next;
    logic        redir_ok, redir_bad, ar_hs, r_hs;

    assign redir_ok  = redirect && (target[1:0] == 2'b00) && (state != HALT);
    assign redir_bad = redirect && (target[1:0] != 2'b00) && (state != HALT);
    assign ar_valid  = (state == REQ);
    assign ar_addr   = addr_q;
    assign r_ready   = (state == WAIT) && (!tvalid || tready);
    assign ar_hs     = ar_valid && ar_ready;
    assign r_hs      = r_valid && r_ready;

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        kill_next      = kill;
        halt_pend_next = halt_pend;
        tvalid_next    = tvalid && !tready;
        tdata_next     = tdata;
        mis_next       = misaligned;
        berr_next      = bus_error;
        addr_next      = addr_q;

        case (state)
            IDLE: state_next = redir_bad ? HALT : REQ;
            REQ: begin
                if (ar_hs) state_next = WAIT;
                // The request already presented must still complete; its data is stale.
                if (redir_ok || redir_bad) kill_next = 1'b1;
            end
            WAIT: begin
                if (r_hs) begin
                    kill_next = 1'b0;
                    if (redir_ok || redir_bad || kill) begin
                        state_next = (redir_bad || halt_pend) ? HALT : REQ;
                    end else if (r_resp != 2'b00) begin
                        berr_next  = 1'b1;
                        state_next = HALT;
                    end else begin
                        tvalid_next = 1'b1;
                        tdata_next  = {pc, r_data};
                        pc_next     = pc + 32'd4;
                        state_next  = REQ;
                    end
                end else if (redir_ok || redir_bad) begin
                    kill_next = 1'b1;
                end
            end
            HALT: state_next = HALT;
            default: state_next = IDLE;
        endcase

        if (redir_ok) begin
            pc_next     = target;
            tvalid_next = 1'b0;
        end
        if (redir_bad) begin
            mis_next       = 1'b1;
            tvalid_next    = 1'b0;
            halt_pend_next = 1'b1;
        end

        // Latch the address only on entry to REQ so it cannot move under a pending request.
        if (state_next == REQ && state != REQ) addr_next = pc_next;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            pc         <= RESET_ADDR;
            addr_q     <= RESET_ADDR;
            kill       <= 1'b0;
            halt_pend  <= 1'b0;
            tvalid     <= 1'b0;
            tdata      <= 64'd0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            addr_q     <= addr_next;
            kill       <= kill_next;
            halt_pend  <= halt_pend_next;
            tvalid     <= tvalid_next;
            tdata      <= tdata_next;
            misaligned <= mis_next;
            bus_error  <= berr_next;
        end
    end
endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: a memory responder drives the read channel and an
// in-order scoreboard checks read addresses and stream beats.
module tb_fetch;
    localparam logic [31:0] RST_ADDR = 32'h0000_0100;

    logic        aclk = 1'b0;
    logic        areset, redirect, ar_valid, ar_ready, r_valid, r_ready;
    logic        tvalid, tready, misaligned, bus_error;
    logic [31:0] target, ar_addr, r_data;
    logic [1:0]  r_resp;
    logic [63:0] tdata;

    always #5 aclk = ~aclk;

    fetch #(.RESET_ADDR(RST_ADDR)) dut (
        .aclk(aclk), .areset(areset), .redirect(redirect), .target(target),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .tvalid(tvalid), .tready(tready), .tdata(tdata),
        .misaligned(misaligned), .bus_error(bus_error)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_ar[$];
    int beats, extra_t, ar_cnt, extra_ar, cyc;
    int beat_cyc[$];

    // responder and drive state
    bit          pending;
    logic [31:0] pend_addr, err_addr, tgt_d;
    int          delay_left, r_lat, ar_stall;
    bit          rst_d, redir_d, trdy_d;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
        cyc++;
        areset   = rst_d;
        redirect = redir_d;
        target   = tgt_d;
        tready   = trdy_d;
        redir_d  = 1'b0;
        if (rst_d) pending = 1'b0;
        ar_ready = 1'b1;
        if (ar_valid && ar_stall > 0) begin
            ar_ready = 1'b0;
            ar_stall--;
        end
        r_valid = 1'b0;
        r_data  = mem(pend_addr);
        r_resp  = (pend_addr == err_addr) ? 2'b10 : 2'b00;
        if (pending) begin
            if (delay_left > 0) delay_left--;
            else r_valid = 1'b1;
        end
        #1;
        if (!areset) begin
            if (r_valid && r_ready) pending = 1'b0;
            if (ar_valid && ar_ready) begin
                ar_cnt++;
                if (exp_ar.size() > 0) check("ar_addr", ar_addr, exp_ar.pop_front());
                else extra_ar++;
                pending    = 1'b1;
                pend_addr  = ar_addr;
                delay_left = r_lat;
            end
            if (tvalid && tready) begin
                beats++;
                beat_cyc.push_back(cyc);
                if (exp_q.size() > 0) check("tdata", tdata, exp_q.pop_front());
                else extra_t++;
            end
        end
    endtask

    task automatic do_reset();
        rst_d = 1'b1;
        redir_d = 1'b0;
        exp_q.delete();
        exp_ar.delete();
        beat_cyc.delete();
        beats = 0; extra_t = 0; extra_ar = 0; ar_cnt = 0;
        step();
        step();
        rst_d = 1'b0;
        step();
    endtask

    task automatic reset_checks();
        check("rst_ar_valid", ar_valid, 0);
        check("rst_r_ready", r_ready, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_misaligned", misaligned, 0);
        check("rst_bus_error", bus_error, 0);
    endtask

    task automatic run_until_beats(input int n, input int budget);
        for (int i = 0; i < budget && beats < n; i++) step();
        check("beats", beats, n);
    endtask

    initial begin
        areset = 1'b1; redirect = 1'b0; target = 32'h0; tready = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = 32'h0; r_resp = 2'b00;
        pending = 1'b0; pend_addr = 32'h0; delay_left = 0; cyc = 0;
        r_lat = 0; ar_stall = 0; err_addr = 32'hFFFF_FFF0;
        tgt_d = 32'h0; trdy_d = 1'b1; rst_d = 1'b1; redir_d = 1'b0;

        // zero-wait streaming, one beat per two cycles
        do_reset();
        reset_checks();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h104); exp_ar.push_back(32'h108);
        exp_q.push_back(64'h0000_0100_0000_0113);
        exp_q.push_back(64'h0000_0104_0000_0117);
        run_until_beats(2, 20);
        if (beat_cyc.size() == 2) check("t_spacing", beat_cyc[1] - beat_cyc[0], 2);
        check("ar_count", ar_cnt, 3);

        // downstream stall for 5 cycles on the first output
        trdy_d = 1'b0;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h104); exp_ar.push_back(32'h108);
        exp_ar.push_back(32'h10C); exp_ar.push_back(32'h110);
        exp_q.push_back(64'h0000_0100_0000_0113); exp_q.push_back(64'h0000_0104_0000_0117);
        exp_q.push_back(64'h0000_0108_0000_011B); exp_q.push_back(64'h0000_010C_0000_011F);
        step();
        step();
        begin
            int ar_before;
            ar_before = ar_cnt;
            for (int k = 0; k < 5; k++) begin
                step();
                check("stall_tvalid", tvalid, 1);
                check("stall_tdata", tdata, 64'h0000_0100_0000_0113);
                if (k > 0) check("stall_r_ready", r_ready, 0);
            end
            check("stall_ar_hs", ar_cnt - ar_before, 1);
        end
        trdy_d = 1'b1;
        run_until_beats(4, 30);
        check("stall_extra_t", extra_t, 0);

        // redirect during WAIT, response arrives two cycles later
        r_lat = 2;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h200); exp_ar.push_back(32'h204);
        exp_q.push_back(64'h0000_0200_0000_0213);
        step();
        redir_d = 1'b1; tgt_d = 32'h200;
        step();
        step();
        r_lat = 0;
        step();
        check("kill_tvalid", tvalid, 0);
        step();
        check("kill_tvalid2", tvalid, 0);
        check("kill_ar_valid", ar_valid, 1);
        run_until_beats(1, 20);

        // redirect while address channel is stalled
        ar_stall = 3;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h300); exp_ar.push_back(32'h304);
        exp_q.push_back(64'h0000_0300_0000_0313);
        redir_d = 1'b1; tgt_d = 32'h300;
        step();
        check("hold_addr0", ar_addr, 32'h100);
        step();
        check("hold_addr1", ar_addr, 32'h100);
        check("hold_valid1", ar_valid, 1);
        step();
        check("hold_addr2", ar_addr, 32'h100);
        step();
        run_until_beats(1, 20);

        // misaligned redirect with an output held and a request in flight
        trdy_d = 1'b0; ar_stall = 0;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h104);
        step();
        step();
        redir_d = 1'b1; tgt_d = 32'h402;
        step();
        step();
        check("mis_flag", misaligned, 1);
        check("mis_tvalid", tvalid, 0);
        trdy_d = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("mis_ar_valid", ar_valid, 0);
        end
        check("mis_extra_ar", extra_ar, 0);
        check("mis_beats", beats, 0);
        do_reset();
        reset_checks();
        exp_ar.push_back(32'h100);
        step();
        check("mis_restart", ar_cnt, 1);

        // error response at 0x108
        err_addr = 32'h108;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'h104); exp_ar.push_back(32'h108);
        exp_q.push_back(64'h0000_0100_0000_0113);
        exp_q.push_back(64'h0000_0104_0000_0117);
        for (int k = 0; k < 10; k++) step();
        check("berr_flag", bus_error, 1);
        check("berr_ar_valid", ar_valid, 0);
        check("berr_tvalid", tvalid, 0);
        check("berr_beats", beats, 2);
        check("berr_extra_ar", extra_ar, 0);
        check("berr_extra_t", extra_t, 0);

        // redirect on an erroring response, then PC wrap
        err_addr = 32'h100;
        do_reset();
        exp_ar.push_back(32'h100); exp_ar.push_back(32'hFFFF_FFFC); exp_ar.push_back(32'h0);
        exp_q.push_back(64'hFFFF_FFFC_0000_000F);
        exp_q.push_back(64'h0000_0000_0000_0013);
        step();
        redir_d = 1'b1; tgt_d = 32'hFFFF_FFFC;
        step();
        run_until_beats(2, 20);
        check("wrap_bus_error", bus_error, 0);
        check("wrap_ar_count", ar_cnt, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
